// File: rtl/peri_pwm_multi_if.sv
// Wishbone B4 classic 8-bit bus bundle for the multi-channel PWM peripheral.
interface peri_pwm_multi_if;
    logic       wb_we_i;
    logic [3:0] wb_adr_i;
    logic [7:0] wb_dat_i;
    logic       wb_stb_i;
    logic [7:0] wb_dat_o;
    logic       wb_ack_o;

    modport master (
        output wb_we_i, wb_adr_i, wb_dat_i, wb_stb_i,
        input  wb_dat_o, wb_ack_o
    );

    modport slave (
        input  wb_we_i, wb_adr_i, wb_dat_i, wb_stb_i,
        output wb_dat_o, wb_ack_o
    );
endinterface

// File: rtl/peri_pwm_multi.sv
// Multi-channel PWM peripheral: double-buffered duty/period/prescaler applied at
// period boundaries, per-channel polarity, full register readback over Wishbone.
module peri_pwm_multi #(
    parameter int unsigned CHANNELS = 3,
    parameter int unsigned RES      = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    peri_pwm_multi_if.slave     bus,
    output logic [CHANNELS-1:0] pwm_o
);
    localparam int unsigned AW = 4;
    localparam int unsigned DW = 8;
    localparam int unsigned PW = 8;

    localparam logic [AW-1:0]  ADR_CTRL  = 4'hC;
    localparam logic [AW-1:0]  ADR_PRESC = 4'hD;
    localparam logic [AW-1:0]  ADR_TOP   = 4'hE;
    localparam logic [AW-1:0]  ADR_INV   = 4'hF;
    localparam logic [RES-1:0] TOP_RST   = {RES{1'b1}};

    typedef logic [CHANNELS-1:0][RES-1:0] duty_t;

    duty_t               duty_s, duty_s_n, duty_a, duty_a_n;
    logic [PW-1:0]       presc_s, presc_s_n, presc_a, presc_a_n;
    logic [PW-1:0]       div, div_n;
    logic [RES-1:0]      top_s, top_s_n, top_a, top_a_n;
    logic [RES-1:0]      cnt, cnt_n;
    logic [CHANNELS-1:0] inv, inv_n, raw;
    logic                en, en_n, pend, pend_n, ack_n;
    logic [DW-1:0]       rdata_n;
    logic                acc, wr, rd, buf_wr, tick, boundary, load;

    // Bus decode, shadow updates, counter advance and boundary reload.
    always_comb begin
        acc      = bus.wb_stb_i && !bus.wb_ack_o;
        wr       = acc && bus.wb_we_i;
        rd       = acc && !bus.wb_we_i;
        duty_s_n = duty_s;
        presc_s_n = presc_s;
        top_s_n  = top_s;
        inv_n    = inv;
        en_n     = en;
        buf_wr   = 1'b0;
        rdata_n  = '0;
        ack_n    = acc;

        if (wr) begin
            for (int unsigned n = 0; n < CHANNELS; n++) begin
                if (bus.wb_adr_i == AW'(n)) begin
                    duty_s_n[n] = bus.wb_dat_i[RES-1:0];
                    buf_wr      = 1'b1;
                end
            end
            case (bus.wb_adr_i)
                ADR_CTRL:  en_n = bus.wb_dat_i[0];
                ADR_PRESC: begin
                    presc_s_n = bus.wb_dat_i;
                    buf_wr    = 1'b1;
                end
                ADR_TOP: begin
                    top_s_n = bus.wb_dat_i[RES-1:0];
                    buf_wr  = 1'b1;
                end
                ADR_INV:   inv_n = bus.wb_dat_i[CHANNELS-1:0];
                default:   ;
            endcase
        end

        if (rd) begin
            for (int unsigned n = 0; n < CHANNELS; n++) begin
                if (bus.wb_adr_i == AW'(n)) rdata_n = DW'(duty_s[n]);
            end
            case (bus.wb_adr_i)
                ADR_CTRL:  rdata_n = {pend, 6'b000000, en};
                ADR_PRESC: rdata_n = presc_s;
                ADR_TOP:   rdata_n = DW'(top_s);
                ADR_INV:   rdata_n = DW'(inv);
                default:   ;
            endcase
        end

        tick     = en && (div == presc_a);
        boundary = tick && (cnt == top_a);
        // Actives follow the shadows while stopped, on stop/start, and at a boundary.
        load      = boundary || !en || !en_n;
        duty_a_n  = load ? duty_s_n  : duty_a;
        top_a_n   = load ? top_s_n   : top_a;
        presc_a_n = load ? presc_s_n : presc_a;

        if (!en || !en_n) begin
            div_n = '0;
            cnt_n = '0;
        end else if (tick) begin
            div_n = '0;
            cnt_n = boundary ? '0 : cnt + RES'(1);
        end else begin
            div_n = div + PW'(1);
            cnt_n = cnt;
        end

        pend_n = pend;
        if (load)        pend_n = 1'b0;
        else if (buf_wr) pend_n = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            duty_s       <= '0;
            duty_a       <= '0;
            presc_s      <= '0;
            presc_a      <= '0;
            top_s        <= TOP_RST;
            top_a        <= TOP_RST;
            inv          <= '0;
            en           <= 1'b0;
            pend         <= 1'b0;
            div          <= '0;
            cnt          <= '0;
            bus.wb_ack_o <= 1'b0;
            bus.wb_dat_o <= '0;
        end else begin
            duty_s       <= duty_s_n;
            duty_a       <= duty_a_n;
            presc_s      <= presc_s_n;
            presc_a      <= presc_a_n;
            top_s        <= top_s_n;
            top_a        <= top_a_n;
            inv          <= inv_n;
            en           <= en_n;
            pend         <= pend_n;
            div          <= div_n;
            cnt          <= cnt_n;
            bus.wb_ack_o <= ack_n;
            bus.wb_dat_o <= rdata_n;
        end
    end

    // Compare against registered state only, so the pins never glitch on bus activity.
    always_comb begin
        for (int unsigned n = 0; n < CHANNELS; n++) raw[n] = (cnt < duty_a[n]);
        pwm_o = raw ^ inv;
    end
endmodule

// File: tb/tb_peri_pwm_multi.sv
// Randomised and directed bench for peri_pwm_multi against a period-phase model.
module tb_peri_pwm_multi;
    localparam int CH  = 3;
    localparam int RES = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [CH-1:0] pwm;
    logic [CH-1:0] pwm_at_ack;

    peri_pwm_multi_if bus ();

    peri_pwm_multi #(.CHANNELS(CH), .RES(RES)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus),
        .pwm_o (pwm)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    bit live  = 1'b0;

    // Model state: shadows, actives, and t = clocks elapsed in the current period.
    int m_duty_s [CH];
    int m_duty_a [CH];
    int m_presc_s, m_presc_a, m_top_s, m_top_a, m_inv, m_t, m_rdata;
    bit m_en, m_pend, m_ack, m_rd;

    int periods = 0, run_hi = 0, run_len = 0, last_hi = 0, last_len = 0;

    task automatic chk(input string nm, input int act, input int want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, want, $time);
        end
    endtask

    function automatic int model_read(input int a);
        if (a < CH) return m_duty_s[a];
        case (a)
            12:      return (m_pend ? 128 : 0) + (m_en ? 1 : 0);
            13:      return m_presc_s;
            14:      return m_top_s;
            15:      return m_inv;
            default: return 0;
        endcase
    endfunction

    always @(posedge clk) begin : model
        bit acc, bw, ne, bnd;
        int a, d, rv;
        if (rst) begin
            for (int n = 0; n < CH; n++) begin
                m_duty_s[n] = 0;
                m_duty_a[n] = 0;
            end
            m_presc_s = 0; m_presc_a = 0;
            m_top_s = (1 << RES) - 1; m_top_a = (1 << RES) - 1;
            m_inv = 0; m_en = 0; m_pend = 0; m_t = 0;
            m_ack = 0; m_rd = 0; m_rdata = 0;
        end else begin
            acc = bus.wb_stb_i && !m_ack;
            a   = int'(bus.wb_adr_i);
            d   = int'(bus.wb_dat_i);
            rv  = (acc && !bus.wb_we_i) ? model_read(a) : 0;
            ne  = m_en;
            bw  = 0;
            if (acc && bus.wb_we_i) begin
                if (a < CH) begin m_duty_s[a] = d & ((1 << RES) - 1); bw = 1; end
                else if (a == 12) ne = d[0];
                else if (a == 13) begin m_presc_s = d; bw = 1; end
                else if (a == 14) begin m_top_s = d & ((1 << RES) - 1); bw = 1; end
                else if (a == 15) m_inv = d & ((1 << CH) - 1);
            end
            bnd = m_en && (m_t == (m_top_a + 1) * (m_presc_a + 1) - 1);
            if (m_en && ne && !bnd) begin
                m_t++;
                if (bw) m_pend = 1;
            end else begin
                m_t = 0;
                for (int n = 0; n < CH; n++) m_duty_a[n] = m_duty_s[n];
                m_top_a = m_top_s; m_presc_a = m_presc_s; m_pend = 0;
            end
            m_en = ne; m_ack = acc; m_rd = acc && !bus.wb_we_i; m_rdata = rv;
        end
    end

    // Every-cycle compare plus per-period high-time/length tracking of channel 0.
    always @(negedge clk) begin : cmp
        logic [CH-1:0] e;
        int c;
        if (live) begin
            c = m_en ? m_t / (m_presc_a + 1) : 0;
            for (int n = 0; n < CH; n++) e[n] = (c < m_duty_a[n]) ^ m_inv[n];
            chk("pwm", int'(pwm), int'(e));
            chk("ack", int'(bus.wb_ack_o), int'(m_ack));
            if (m_rd) chk("rdata", int'(bus.wb_dat_o), m_rdata);
            if (m_en) begin
                if (m_t == 0) begin
                    last_hi = run_hi; last_len = run_len;
                    run_hi = 0; run_len = 0; periods++;
                end
                run_hi += int'(pwm[0]);
                run_len++;
            end
        end
    end

    task automatic wr(input int a, input int d);
        bus.wb_stb_i = 1; bus.wb_we_i = 1;
        bus.wb_adr_i = 4'(a); bus.wb_dat_i = 8'(d);
        @(negedge clk);
        chk("wr_ack", int'(bus.wb_ack_o), 1);
        pwm_at_ack = pwm;
        bus.wb_stb_i = 0; bus.wb_we_i = 0;
        @(negedge clk);
    endtask

    task automatic rd(input int a, output int d);
        bus.wb_stb_i = 1; bus.wb_we_i = 0; bus.wb_adr_i = 4'(a);
        @(negedge clk);
        chk("rd_ack", int'(bus.wb_ack_o), 1);
        d = int'(bus.wb_dat_o);
        bus.wb_stb_i = 0;
        @(negedge clk);
    endtask

    task automatic wait_periods(input int target);
        int k;
        for (k = 0; k < 2000 && periods < target; k++) begin
            @(negedge clk);
            #1;
        end
        if (periods < target) chk("period_timeout", periods, target);
    endtask

    task automatic check_reset_regs(input string tag);
        int v;
        int adrs [7] = '{0, 1, 2, 12, 13, 14, 15};
        for (int i = 0; i < 7; i++) begin
            rd(adrs[i], v);
            chk($sformatf("%s_reg%0d", tag, adrs[i]), v, (adrs[i] == 14) ? 255 : 0);
        end
    endtask

    initial begin
        int v, p0, acks, r;
        rst = 1;
        bus.wb_stb_i = 0; bus.wb_we_i = 0; bus.wb_adr_i = '0; bus.wb_dat_i = '0;
        repeat (2) @(negedge clk);
        rst = 0; live = 1;

        // Reset values
        chk("reset_pwm", int'(pwm), 0);
        check_reset_regs("reset");

        // TOP=9, PRESC=1, DUTY0=3 -> 6 high / 20 period
        wr(14, 9); wr(13, 1); wr(0, 3);
        p0 = periods;
        wr(12, 1);
        wait_periods(p0 + 2);
        chk("hi_duty3", last_hi, 6);
        chk("len_duty3", last_len, 20);

        // Mid-period duty change is held until the boundary
        repeat (4) @(negedge clk);
        wr(0, 7);
        rd(12, v); chk("ctrl_pend", v, 8'h81);
        wait_periods(p0 + 3);
        chk("hi_held", last_hi, 6);
        wait_periods(p0 + 4);
        chk("hi_duty7", last_hi, 14);
        chk("len_duty7", last_len, 20);
        rd(12, v); chk("ctrl_applied", v, 8'h01);

        // Edge duties with TOP=4
        wr(12, 0); wr(14, 4); wr(0, 0); wr(1, 5); wr(2, 255); wr(12, 1);
        repeat (3) @(negedge clk);
        for (int i = 0; i < 12; i++) begin
            chk("edge_duty", int'(pwm), 3'b110);
            @(negedge clk);
        end
        wr(15, 7);
        chk("inv_next_cycle", int'(pwm_at_ack), 3'b001);
        repeat (5) @(negedge clk);
        chk("inv_steady", int'(pwm), 3'b001);
        wr(15, 0);

        // Stop mid-period, shrink TOP, restart
        repeat (3) @(negedge clk);
        wr(0, 1);
        wr(12, 0);
        chk("stop_idle", int'(pwm_at_ack), 3'b111);
        rd(12, v); chk("ctrl_stopped", v, 0);
        wr(14, 2);
        wr(12, 1);
        p0 = periods;
        rd(12, v); chk("ctrl_restart", v, 8'h01);
        wait_periods(p0 + 1);
        chk("len_top2", last_len, 6);
        chk("hi_top2", last_hi, 2);

        // Reset mid-period
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        chk("midreset_pwm", int'(pwm), 0);
        check_reset_regs("midreset");

        // Reserved addresses
        wr(5, 8'hAA);
        chk("rsvd_pwm", int'(pwm_at_ack), 0);
        rd(5, v); chk("rsvd_rd5", v, 0);
        wr(11, 8'hFF);
        rd(11, v); chk("rsvd_rd11", v, 0);

        // Held strobe acks every other cycle
        bus.wb_stb_i = 1; bus.wb_we_i = 0; bus.wb_adr_i = 4'hE;
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            acks += int'(bus.wb_ack_o);
        end
        bus.wb_stb_i = 0;
        @(negedge clk);
        chk("held_stb_acks", acks, 3);

        // Randomised traffic
        for (int i = 0; i < 500; i++) begin
            r = $urandom_range(0, 99);
            if (r < 2) begin
                rst = 1; @(negedge clk); rst = 0;
            end else if (r < 12) wr(12, ($urandom_range(0, 3) != 0) ? 1 : 0);
            else if (r < 22) wr(13, $urandom_range(0, 3));
            else if (r < 32) wr(14, $urandom_range(0, 12));
            else if (r < 52) wr($urandom_range(0, CH - 1),
                                ($urandom_range(0, 7) == 0) ? 255 : $urandom_range(0, 14));
            else if (r < 58) wr(15, $urandom_range(0, 7));
            else if (r < 64) wr($urandom_range(3, 11), $urandom);
            else if (r < 80) rd($urandom_range(0, 15), v);
            else repeat ($urandom_range(1, 12)) @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
